// File: rtl/dac_spi_driver.sv
// rtl/dac_spi_driver.sv - dual-word SPI driver for an X/Y DAC with shared LDAC latch
module dac_spi_driver #(
    parameter int unsigned CLK_DIV = 4,
    parameter bit          BUF     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] DAC_x,
    input  logic [11:0] DAC_y,
    input  logic        DAC_start,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        dac_ldac_n,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_X,
        GAP,
        SHIFT_Y,
        LATCH
    } state_t;

    // Divider is 8 bits so CLK_DIV=255 (terminal count 254) never wraps.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q;
    logic [7:0]  div_q;
    logic [3:0]  bit_q;
    logic [15:0] sh_q;
    logic [15:0] y_word_q;
    logic        cs_n_q;
    logic        sclk_q;
    logic        din_q;
    logic        ldac_n_q;
    logic        busy_q;
    logic        done_q;
    logic        overrun_q;

    logic [15:0] x_word;
    logic [15:0] y_word;
    logic        div_last;

    // Channel select in bit 15 (0 = X, 1 = Y), then buffer bit, gain and active bits.
    assign x_word   = {1'b0, BUF, 2'b11, DAC_x};
    assign y_word   = {1'b1, BUF, 2'b11, DAC_y};
    assign div_last = (div_q == DIV_LAST);

    // Sequencer: every output is a register updated together with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            y_word_q  <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            din_q     <= 1'b0;
            ldac_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (DAC_start && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (DAC_start) begin
                        din_q    <= x_word[15];
                        sh_q     <= {x_word[14:0], 1'b0};
                        y_word_q <= y_word;
                        cs_n_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        div_q    <= '0;
                        bit_q    <= '0;
                        state_q  <= SHIFT_X;
                    end
                end
                SHIFT_X, SHIFT_Y: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // End of the high phase: new bit goes out with the falling edge.
                            sclk_q <= 1'b0;
                            if (bit_q == 4'd15) begin
                                cs_n_q <= 1'b1;
                                din_q  <= 1'b0;
                                if (state_q == SHIFT_X) begin
                                    state_q <= GAP;
                                end else begin
                                    ldac_n_q <= 1'b0;
                                    state_q  <= LATCH;
                                end
                            end else begin
                                bit_q <= bit_q + 4'd1;
                                din_q <= sh_q[15];
                                sh_q  <= {sh_q[14:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                GAP: begin
                    if (div_last) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        cs_n_q  <= 1'b0;
                        din_q   <= y_word_q[15];
                        sh_q    <= {y_word_q[14:0], 1'b0};
                        state_q <= SHIFT_Y;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                LATCH: begin
                    if (div_last) begin
                        div_q    <= '0;
                        ldac_n_q <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = din_q;
    assign dac_ldac_n = ldac_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_dac_spi_driver.sv
// tb/tb_dac_spi_driver.sv - scoreboard bench for dac_spi_driver at CLK_DIV 4 and 1
module tb_dac_spi_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] dac_x = '0;
    logic [11:0] dac_y = '0;
    logic        start4 = 1'b0;
    logic        start1 = 1'b0;

    logic cs4, sclk4, din4, ldac4, busy4, done4, ovr4;
    logic cs1, sclk1, din1, ldac1, busy1, done1, ovr1;

    always #5 clk = ~clk;

    dac_spi_driver #(.CLK_DIV(4), .BUF(1'b0)) dut4 (
        .clk(clk), .reset(reset), .DAC_x(dac_x), .DAC_y(dac_y), .DAC_start(start4),
        .dac_cs_n(cs4), .dac_sclk(sclk4), .dac_din(din4), .dac_ldac_n(ldac4),
        .busy(busy4), .done(done4), .overrun(ovr4)
    );

    dac_spi_driver #(.CLK_DIV(1), .BUF(1'b0)) dut1 (
        .clk(clk), .reset(reset), .DAC_x(dac_x), .DAC_y(dac_y), .DAC_start(start1),
        .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_din(din1), .dac_ldac_n(ldac1),
        .busy(busy1), .done(done1), .overrun(ovr1)
    );

    // Monitor watches whichever instance sel picks.
    logic sel = 1'b0;
    logic m_cs, m_sclk, m_din, m_ldac, m_busy, m_done, m_ovr;
    int   div;
    always_comb begin
        m_cs   = sel ? cs1   : cs4;
        m_sclk = sel ? sclk1 : sclk4;
        m_din  = sel ? din1  : din4;
        m_ldac = sel ? ldac1 : ldac4;
        m_busy = sel ? busy1 : busy4;
        m_done = sel ? done1 : done4;
        m_ovr  = sel ? ovr1  : ovr4;
        div    = sel ? 1 : 4;
    end

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor state
    logic        p_cs = 1'b1, p_sclk = 1'b0, p_din = 1'b0, p_busy = 1'b0, p_ldac = 1'b1;
    logic [15:0] acc = '0;
    int          nbits = 0, run = 0, busy_run = 0, ldac_run = 0, gap_run = 0;
    logic        half = 1'b0;
    int          done_cnt = 0, ldac_cnt = 0;
    logic [15:0] req_word;

    always @(negedge clk) begin
        if (reset) begin
            p_cs = 1'b1; p_sclk = 1'b0; p_din = 1'b0; p_busy = 1'b0; p_ldac = 1'b1;
            acc = '0; nbits = 0; run = 0; busy_run = 0; ldac_run = 0; gap_run = 0; half = 1'b0;
        end else begin
            if (m_sclk && !p_sclk) begin
                chk("din_stable_at_rise", m_din, p_din);
                chk("cs_low_at_rise", m_cs, 1'b0);
                acc = {acc[14:0], m_din};
                nbits++;
            end
            if (!p_cs) begin
                if (m_sclk != p_sclk || m_cs) begin
                    chk("sclk_phase_len", run, div);
                    run = 1;
                end else begin
                    run++;
                end
            end else begin
                run = 1;
            end
            if (!p_cs && m_cs) begin
                chk("bits_per_word", nbits, 16);
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", acc, 32'hFFFF_FFFF);
                end else begin
                    req_word = exp_q.pop_front();
                    chk("word", acc, req_word);
                end
                half = ~half;
                gap_run = 1;
            end else if (p_cs && !m_cs) begin
                if (half) chk("cs_gap_len", gap_run, div);
                gap_run = 0; acc = '0; nbits = 0;
            end else if (m_cs) begin
                gap_run++;
            end
            if (m_busy) busy_run++;
            if (p_busy && !m_busy) begin
                chk("busy_len", busy_run, 66 * div);
                chk("done_when_busy_drops", m_done, 1'b1);
                busy_run = 0;
            end
            if (!m_ldac) begin
                ldac_run++;
                chk("cs_high_during_ldac", m_cs, 1'b1);
                half = 1'b0;
            end
            if (!p_ldac && m_ldac) begin
                chk("ldac_len", ldac_run, div);
                chk("done_after_ldac", m_done, 1'b1);
                ldac_cnt++;
                ldac_run = 0;
            end
            if (m_done) done_cnt++;
            p_cs = m_cs; p_sclk = m_sclk; p_din = m_din; p_busy = m_busy; p_ldac = m_ldac;
        end
    end

    task automatic issue(input logic [11:0] x, input logic [11:0] y, input logic push);
        @(posedge clk); #1;
        dac_x = x; dac_y = y;
        if (sel) start1 = 1'b1; else start4 = 1'b1;
        if (push) begin
            exp_q.push_back({4'b0011, x});
            exp_q.push_back({4'b1011, y});
        end
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!m_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
    endtask

    int d0, l0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_outputs_div4", {cs4, sclk4, din4, ldac4, busy4, done4, ovr4}, 7'b1001000);
        chk("reset_outputs_div1", {cs1, sclk1, din1, ldac1, busy1, done1, ovr1}, 7'b1001000);

        // Basic point: words 0x3ABC, 0xB123.
        issue(12'hABC, 12'h123, 1'b1);
        chk("busy_after_accept", m_busy, 1'b1);
        chk("cs_low_after_accept", m_cs, 1'b0);
        wait_done("basic");
        @(negedge clk);
        chk("done_one_cycle", m_done, 1'b0);
        chk("done_count_basic", done_cnt, 1);
        chk("ldac_count_basic", ldac_cnt, 1);
        chk("no_overrun_basic", m_ovr, 1'b0);

        // Start during transfer is ignored but flags overrun.
        issue(12'h456, 12'h789, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        dac_x = 12'h555; dac_y = 12'hAAA; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("overrun_set", m_ovr, 1'b1);
        wait_done("overrun");
        chk("overrun_sticky_after_done", m_ovr, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("overrun_still_sticky", m_ovr, 1'b1);
        chk("done_count_overrun", done_cnt, 2);

        do_reset();
        chk("overrun_cleared_by_reset", m_ovr, 1'b0);

        // Back-to-back: start presented on the done cycle.
        issue(12'h0F0, 12'hF0F, 1'b1);
        wait_done("b2b_first");
        chk("busy_low_on_done", m_busy, 1'b0);
        dac_x = 12'h800; dac_y = 12'h7FF; start4 = 1'b1;
        exp_q.push_back(16'h3800);
        exp_q.push_back(16'hB7FF);
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("b2b_cs_low_next_cycle", m_cs, 1'b0);
        chk("b2b_busy_next_cycle", m_busy, 1'b1);
        wait_done("b2b_second");
        @(posedge clk); #1;
        chk("b2b_no_overrun", m_ovr, 1'b0);
        chk("done_count_b2b", done_cnt, 4);

        // Reset during SHIFT_Y aborts with no LDAC and no done.
        issue(12'h111, 12'h222, 1'b1);
        repeat (150) @(posedge clk);
        #1;
        d0 = done_cnt; l0 = ldac_cnt;
        chk("in_shift_y_before_reset", {m_cs, m_busy}, 2'b01);
        do_reset();
        chk("abort_idle_outputs", {cs4, sclk4, din4, ldac4, busy4, done4, ovr4}, 7'b1001000);
        repeat (300) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);
        chk("abort_no_ldac", ldac_cnt, l0);
        chk("abort_stays_idle", {cs4, ldac4, busy4}, 3'b110);

        // CLK_DIV=1 instance: words 0x3FFF, 0xB000, busy 66 cycles.
        sel = 1'b1;
        issue(12'hFFF, 12'h000, 1'b1);
        wait_done("div1");
        @(posedge clk); #1;
        chk("done_count_div1", done_cnt, d0 + 1);
        chk("ldac_count_div1", ldac_cnt, l0 + 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
